// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: op encoding, FSM states, div-by-zero fill.
package exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SRL   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REMU  = 4'hD;

  // Quotient of a divide by zero is every bit set to this value.
  localparam logic DIV0_Q_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU take the upper/remainder half of the iterative datapath.
  function automatic logic is_hi(input logic [3:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_unit_mc_if.sv
// Upstream operand handshake and downstream result handshake of the execute unit.
interface exec_unit_mc_if #(parameter int unsigned XLEN = 64) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] imm;
  logic            alu_src;
  logic [3:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, a, b, imm, alu_src, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, imm, alu_src, op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative unsigned multiply (shift-add) and restoring divide, XLEN steps.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] acc, mq, mcand;
  logic            mul_mode, hi_sel, running;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] acc_s, mq_s, mcand_s, acc_n, mq_n, diff;
  logic [XLEN:0]   sum, sh;
  logic            mul_s;

  // The first step is taken on the load cycle straight from the incoming operands.
  always_comb begin
    acc_s   = start ? '0 : acc;
    mq_s    = start ? a : mq;
    mcand_s = start ? b : mcand;
    mul_s   = start ? !is_div(op) : mul_mode;
    sum     = {1'b0, acc_s} + (mq_s[0] ? {1'b0, mcand_s} : '0);
    sh      = {acc_s, mq_s[XLEN-1]};
    diff    = sh[XLEN-1:0] - mcand_s;
    if (mul_s) begin
      acc_n = sum[XLEN:1];
      mq_n  = {sum[0], mq_s[XLEN-1:1]};
    end else if (sh >= {1'b0, mcand_s}) begin
      acc_n = diff;
      mq_n  = {mq_s[XLEN-2:0], 1'b1};
    end else begin
      acc_n = sh[XLEN-1:0];
      mq_n  = {mq_s[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      mul_mode <= 1'b0;
      hi_sel   <= 1'b0;
      running  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      res      <= '0;
    end else begin
      done <= 1'b0;
      if (start || running) begin
        acc <= acc_n;
        mq  <= mq_n;
      end
      if (start) begin
        mcand    <= b;
        mul_mode <= !is_div(op);
        hi_sel   <= is_hi(op);
        cnt      <= CW'(1);
        running  <= 1'b1;
      end else if (running) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(XLEN - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          res     <= hi_sel ? acc_n : mq_n;
        end
      end
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU ops inline, mul/div through the iterative datapath.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_unit_mc_if.slave  bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state, state_n;
  logic [XLEN-1:0] opb, alu_res, res_n, result_q, md_res;
  logic [SHW-1:0]  shamt;
  logic            zero_q, accept, div0, md_start, md_done, res_load;

  assign opb          = bus.alu_src ? bus.imm : bus.b;
  assign shamt        = opb[SHW-1:0];
  assign div0         = is_div(bus.op) && (opb == '0);
  assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;

  // Single-cycle results; DIVU/REMU entries only matter for the divide-by-zero shortcut.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.a + opb;
      OP_SUB:  alu_res = bus.a - opb;
      OP_AND:  alu_res = bus.a & opb;
      OP_OR:   alu_res = bus.a | opb;
      OP_XOR:  alu_res = bus.a ^ opb;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRA:  alu_res = XLEN'($signed(bus.a) >>> shamt);
      OP_SLT:  alu_res[0] = $signed(bus.a) < $signed(opb);
      OP_SLTU: alu_res[0] = bus.a < opb;
      OP_DIVU: alu_res = {XLEN{DIV0_Q_FILL}};
      OP_REMU: alu_res = bus.a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    res_load = 1'b0;
    res_n    = alu_res;
    md_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_muldiv(bus.op) && !div0) begin
            md_start = 1'b1;
            state_n  = ST_BUSY;
          end else begin
            res_load = 1'b1;
            state_n  = ST_DONE;
          end
        end else if ((state == ST_DONE) && bus.out_ready) begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          res_load = 1'b1;
          res_n    = md_res;
          state_n  = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (res_load) begin
        result_q <= res_n;
        zero_q   <= (res_n == '0);
      end
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (bus.op),
    .a     (bus.a),
    .b     (opb),
    .done  (md_done),
    .res   (md_res)
  );

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised execute-stage unit that replaces the single-cycle combinational ALU path.
- Performs all base integer ops, with a registered output and a 1-cycle latency.
- Adds multi-cycle iterative multiply/divide (MUL, MULHU, DIVU, REMU).
- Sits between decode/register-read and memory stage; valid/ready handshake on both sides so the pipeline can stall on long ops.

Parameters:
- XLEN, 64, datapath width in bits (power of two, >= 8)
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept an op this cycle
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2)
- imm  in  XLEN  sign-extended immediate
- alu_src  in  1  1: operand B = imm, 0: operand B = b
- op  in  4  operation select (encoding below)
- out_valid  out  1  result held valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered with result

Behaviour:
- Reset (async assert, sync deassert by design of the reset source): state=IDLE, out_valid=0, result=0, zero=0, in_ready=1 once reset releases.
- opB = alu_src ? imm : b; applies to every op including SLT/SLTU and mul/div.
- op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SRL, 0110 SLL, 0111 SRA; shift amount = opB[SHW-1:0]
  - 1000 SLT signed, 1001 SLTU; result = {XLEN-1 zeros, flag}
  - 1010 MUL low XLEN bits; 1011 MULHU high XLEN bits of unsigned product
  - 1100 DIVU quotient; 1101 REMU remainder
  - 1110/1111 illegal, result 0
- ADD/SUB wrap modulo 2^XLEN; carry discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, in_valid & single-cycle op: compute, register result, go to DONE. Latency = 1 cycle from accept to out_valid.
  - IDLE, in_valid & mul/div op: latch operands, clear iteration counter, go to BUSY.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide); exactly XLEN cycles, then register result and go to DONE. Total latency = XLEN+1 cycles.
  - DONE: out_valid=1; result/zero held stable until out_ready.
    - out_ready & in_valid: back-to-back accept, same rules as IDLE.
    - out_ready & !in_valid: go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); 0 in BUSY.
- Divide by zero (DIVU/REMU, opB==0): no iteration; DONE after 1 cycle with quotient = all ones and remainder = a.
- Inputs change while BUSY: ignored (operands latched).
- rst_n asserted mid-BUSY: op abandoned, no result produced, state=IDLE.
- zero is computed from the final registered result for every op, including mul/div.

Decomposition:
- Shared package exec_pkg:
  - op encoding localparams (OP_ADD..OP_REMU)
  - FSM state enum
  - DIV0 quotient constant
- One natural sub-module: muldiv_iter, the iterative mul/div datapath.
  - Interface: start, op, a, opB in; done, res out.
  - Holds the iteration counter and accumulator/remainder registers.
- Single-cycle ops stay inline in exec_unit_mc.

Test Plan:
- XLEN=64, ADD a=0xFFFF_FFFF_FFFF_FFFF b=1 -> result=0, zero=1, out_valid exactly 1 cycle after accept.
- alu_src=1, imm=-1 (all ones), SLT a=0 -> result=0; SLTU a=0 -> result=1; SRA a=0x8000_0000_0000_0000 with imm=63 -> all ones.
- MUL a=0x1_0000_0000 b=0x1_0000_0003 -> result=0x3_0000_0000; MULHU same operands -> 0x1.
  - in_ready=0 for 64 cycles; out_valid asserts on cycle 65.
- DIVU a=100 b=7 -> 14; REMU -> 2; DIVU b=0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REMU b=0 -> 100.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 3+4 -> result=7 stable, in_ready=0.
  - Release with new in_valid SUB 3-4 -> accepted same cycle; next result=0xFFFF_FFFF_FFFF_FFFF.
- Assert rst_n=0 at BUSY cycle 20 of DIVU -> out_valid=0, result=0 immediately.
  - After release, ADD 1+1 -> result=2 with latency 1.
